commit_queue: RTL and testbench

In-order result buffer feeding the commit stage. It allocates one slot per issued instruction, tags the slot with a transaction ID, and merges functional-unit writebacks by that ID. It presents the oldest `NR_COMMIT_PORTS` slots, head first, and frees slots in program order when the commit stage acknowledges them. It sits between issue/writeback and commit, as the producer end of the `commit_instr`/`commit_ack` handshake.

---
 rtl/commit_queue_pkg.sv | 37 +++
 rtl/commit_queue.sv | 125 ++++++++++++
 tb/tb_commit_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_queue_pkg.sv
// Shared types for the commit queue: scoreboard slot layout, exception record
// and the transaction-ID width used by issue, writeback and commit.
package commit_queue_pkg;

    localparam int unsigned NR_SB_ENTRIES = 8;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_LOAD,
        FU_STORE,
        FU_BRANCH,
        FU_MULT,
        FU_CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order result buffer: allocates slots at the tail, merges writebacks by
// transaction ID and retires up to two slots per cycle from the head.
module commit_queue
    import commit_queue_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  scoreboard_entry_t                             decoded_instr_i,
    input  logic                                          decoded_instr_valid_i,
    output logic                                          decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
    output logic                                          full_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]                  wbdata_i,
    input  exception_t [NR_WB_PORTS-1:0]                  ex_i,
    input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
    output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]       commit_instr_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i
);

    localparam int unsigned CntW = TRANS_ID_BITS + 1;

    scoreboard_entry_t        mem_q [NR_ENTRIES];
    scoreboard_entry_t        mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]    issued_q, issued_d;
    logic [TRANS_ID_BITS-1:0] head_q, head_d;
    logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
    logic [CntW-1:0]          count_q, count_d;

    logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] commitIdx;
    logic retire0;
    logic retire1;

    // full_o comes from the registered count, so a same-cycle retire never frees a slot early
    assign full_o              = (count_q == CntW'(NR_ENTRIES));
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o    = tail_q;

    always_comb begin
        commitIdx      = '0;
        commit_instr_o = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            commitIdx[k]            = head_q + TRANS_ID_BITS'(k);
            commit_instr_o[k]       = mem_q[commitIdx[k]];
            commit_instr_o[k].valid = mem_q[commitIdx[k]].valid & issued_q[commitIdx[k]];
        end
    end

    // Port 1 may only retire behind port 0, keeping retirement strictly in order
    assign retire0 = commit_ack_i[0] & commit_instr_o[0].valid;
    assign retire1 = retire0 & commit_ack_i[1] & commit_instr_o[1].valid;

    always_comb begin
        mem_d    = mem_q;
        issued_d = issued_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        // Ascending port order lets the highest-indexed port win an ID collision
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && issued_q[trans_id_i[p]]) begin
                mem_d[trans_id_i[p]].result = wbdata_i[p];
                mem_d[trans_id_i[p]].valid  = 1'b1;
                if (ex_i[p].valid) begin
                    mem_d[trans_id_i[p]].ex = ex_i[p];
                end
            end
        end

        if (retire0) begin
            issued_d[commitIdx[0]]    = 1'b0;
            mem_d[commitIdx[0]].valid = 1'b0;
        end
        if (retire1) begin
            issued_d[commitIdx[1]]    = 1'b0;
            mem_d[commitIdx[1]].valid = 1'b0;
        end
        head_d = head_q + TRANS_ID_BITS'(retire0) + TRANS_ID_BITS'(retire1);

        if (decoded_instr_ack_o) begin
            mem_d[tail_q]          = decoded_instr_i;
            mem_d[tail_q].valid    = 1'b0;
            mem_d[tail_q].trans_id = tail_q;
            issued_d[tail_q]       = 1'b1;
            tail_d                 = tail_q + TRANS_ID_BITS'(1);
        end

        count_d = count_q + CntW'(decoded_instr_ack_o) - CntW'(retire0) - CntW'(retire1);

        if (flush_i) begin
            issued_d = '0;
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
            issued_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            issued_q <= issued_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_commit_queue.sv
// Testbench for commit_queue: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_commit_queue;
    import commit_queue_pkg::*;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic flush = 1'b0;
    logic dv = 1'b0;
    scoreboard_entry_t dinstr = '0;
    logic ackO;
    logic [2:0] issId;
    logic full;
    logic [3:0][2:0] wbId = '0;
    logic [3:0][63:0] wbData = '0;
    exception_t [3:0] wbEx = '0;
    logic [3:0] wbV = '0;
    scoreboard_entry_t [1:0] cInstr;
    logic [1:0] cAck = '0;

    int nTests = 0;
    int nFail = 0;

    commit_queue dut (
        .clk_i                 (clk),
        .rst_ni                (rstN),
        .flush_i               (flush),
        .decoded_instr_i       (dinstr),
        .decoded_instr_valid_i (dv),
        .decoded_instr_ack_o   (ackO),
        .issue_trans_id_o      (issId),
        .full_o                (full),
        .trans_id_i            (wbId),
        .wbdata_i              (wbData),
        .ex_i                  (wbEx),
        .wb_valid_i            (wbV),
        .commit_instr_o        (cInstr),
        .commit_ack_i          (cAck)
    );

    always #5 clk = ~clk;

    // Reference model: the in-flight instructions in program order, oldest first
    typedef struct packed {
        logic [2:0]  id;
        logic [63:0] pc;
        logic        done;
        logic [63:0] res;
        logic        exv;
        logic [63:0] cause;
    } mEnt_t;

    mEnt_t mq[$];
    int mTail = 0;

    typedef struct packed {
        logic        dv;
        logic        wbv;
        logic [2:0]  wbid;
        logic [63:0] wbdata;
        logic [1:0]  ack;
        logic        eAck;
        logic [2:0]  eId;
        logic        eV0;
        logic        eV1;
        logic [2:0]  eTid0;
        logic [63:0] eRes0;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [1:0] ack, input logic fl);
        dv = v;
        dinstr = '0;
        dinstr.pc = pc;
        dinstr.fu = FU_ALU;
        dinstr.rd = pc[4:0];
        dinstr.trans_id = 3'd7;
        dinstr.valid = 1'b1;
        cAck = ack;
        flush = fl;
        wbV = '0;
        wbId = '0;
        wbData = '0;
        wbEx = '0;
    endtask

    task automatic setWb(input int p, input logic [2:0] id, input logic [63:0] d,
                         input logic exv, input logic [63:0] cause);
        wbV[p] = 1'b1;
        wbId[p] = id;
        wbData[p] = d;
        wbEx[p] = '0;
        wbEx[p].valid = exv;
        wbEx[p].cause = cause;
    endtask

    task automatic checkOutput();
        int n;
        n = mq.size();
        check("ack_o", ackO, dv && !flush && n < 8);
        check("issue_id", issId, mTail);
        check("full", full, n == 8);
        for (int k = 0; k < 2; k++) begin
            if (k < n) begin
                check($sformatf("valid%0d", k), cInstr[k].valid, mq[k].done);
                check($sformatf("trans_id%0d", k), cInstr[k].trans_id, mq[k].id);
                check($sformatf("pc%0d", k), cInstr[k].pc, mq[k].pc);
                if (mq[k].done) begin
                    check($sformatf("result%0d", k), cInstr[k].result, mq[k].res);
                    check($sformatf("exvalid%0d", k), cInstr[k].ex.valid, mq[k].exv);
                    if (mq[k].exv) check($sformatf("cause%0d", k), cInstr[k].ex.cause, mq[k].cause);
                end
            end else begin
                check($sformatf("valid_empty%0d", k), cInstr[k].valid, 1'b0);
            end
        end
    endtask

    task automatic modelStep();
        int n;
        bit r0;
        bit r1;
        mEnt_t e;
        if (flush) begin
            mq.delete();
            mTail = 0;
        end else begin
            n = mq.size();
            r0 = 0;
            r1 = 0;
            if (cAck[0] && n > 0) r0 = mq[0].done;
            if (r0 && cAck[1] && n > 1) r1 = mq[1].done;
            for (int p = 0; p < 4; p++) begin
                if (wbV[p]) begin
                    for (int j = 0; j < n; j++) begin
                        if (mq[j].id == wbId[p]) begin
                            mq[j].done = 1'b1;
                            mq[j].res = wbData[p];
                            if (wbEx[p].valid) begin
                                mq[j].exv = 1'b1;
                                mq[j].cause = wbEx[p].cause;
                            end
                        end
                    end
                end
            end
            if (r0) void'(mq.pop_front());
            if (r1) void'(mq.pop_front());
            if (dv && n < 8) begin
                e = '0;
                e.id = 3'(mTail);
                e.pc = dinstr.pc;
                mq.push_back(e);
                mTail = (mTail + 1) % 8;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        rstN = 1'b0;
        #2;
        check("rst_issue_id", issId, 3'd0);
        check("rst_full", full, 1'b0);
        check("rst_valid0", cInstr[0].valid, 1'b0);
        check("rst_valid1", cInstr[1].valid, 1'b0);
        check("rst_slot0_pc", cInstr[0].pc, 64'd0);
        mq.delete();
        mTail = 0;
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 3'd0, 64'h0,    2'b00, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 3'd0, 64'h0,    2'b00, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 3'd0, 64'h0,    2'b00, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 64'h0};
        vecs[3] = '{1'b0, 1'b1, 3'd1, 64'hBEEF, 2'b00, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0, 64'h0};
        vecs[4] = '{1'b0, 1'b1, 3'd0, 64'h1234, 2'b00, 1'b0, 3'd3, 1'b0, 1'b1, 3'd0, 64'h0};
        vecs[5] = '{1'b0, 1'b0, 3'd0, 64'h0,    2'b11, 1'b0, 3'd3, 1'b1, 1'b1, 3'd0, 64'h1234};
        vecs[6] = '{1'b0, 1'b0, 3'd0, 64'h0,    2'b00, 1'b0, 3'd3, 1'b0, 1'b0, 3'd2, 64'h0};

        #2;
        check("init_issue_id", issId, 3'd0);
        check("init_full", full, 1'b0);
        check("init_ack", ackO, 1'b0);
        check("init_valid0", cInstr[0].valid, 1'b0);
        check("init_valid1", cInstr[1].valid, 1'b0);
        #10;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: allocate three, out-of-order writeback, dual retire
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].dv, 64'h1000 + 64'(i * 4), vecs[i].ack, 1'b0);
            if (vecs[i].wbv) setWb(0, vecs[i].wbid, vecs[i].wbdata, 1'b0, 64'd0);
            #2;
            check($sformatf("vec%0d_ack", i), ackO, vecs[i].eAck);
            check($sformatf("vec%0d_id", i), issId, vecs[i].eId);
            check($sformatf("vec%0d_v0", i), cInstr[0].valid, vecs[i].eV0);
            check($sformatf("vec%0d_v1", i), cInstr[1].valid, vecs[i].eV1);
            check($sformatf("vec%0d_tid0", i), cInstr[0].trans_id, vecs[i].eTid0);
            if (vecs[i].eV0) check($sformatf("vec%0d_res0", i), cInstr[0].result, vecs[i].eRes0);
            cycle();
        end

        // Writeback to a never-issued slot leaves it untouched
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 64'h2000 + 64'(i), 2'b00, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        for (int p = 0; p < 4; p++) setWb(p, 3'(p), 64'hA0 + 64'(p), 1'b0, 64'd0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        setWb(0, 3'd4, 64'hA4, 1'b0, 64'd0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b11, 1'b0);
        cycle();
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b01, 1'b0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        setWb(0, 3'd5, 64'hDEAD, 1'b1, 64'd2);
        cycle();
        check("noniss_valid", cInstr[0].valid, 1'b0);
        check("noniss_result", cInstr[0].result, 64'd0);
        check("noniss_exvalid", cInstr[0].ex.valid, 1'b0);

        // Head wrap: head=7 shows slot 0 on port 1; port collision; exception merge
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h3000 + 64'(i), 2'b00, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        setWb(0, 3'd5, 64'h55, 1'b0, 64'd0);
        setWb(1, 3'd6, 64'h66, 1'b0, 64'd0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b11, 1'b0);
        cycle();
        check("wrap_tid0", cInstr[0].trans_id, 3'd7);
        check("wrap_tid1", cInstr[1].trans_id, 3'd0);
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        setWb(0, 3'd7, 64'h77, 1'b0, 64'd0);
        setWb(1, 3'd0, 64'h100, 1'b1, 64'd5);
        setWb(2, 3'd7, 64'h777, 1'b0, 64'd0);
        cycle();
        check("wrap_v0", cInstr[0].valid, 1'b1);
        check("collide_result", cInstr[0].result, 64'h777);
        check("wrap_v1", cInstr[1].valid, 1'b1);
        check("ex_valid1", cInstr[1].ex.valid, 1'b1);
        applyStimulus(1'b0, 64'd0, 2'b11, 1'b0);
        cycle();
        check("wrap_head1_tid", cInstr[0].trans_id, 3'd1);
        check("wrap_head1_v0", cInstr[0].valid, 1'b0);
        check("wrap_tail", issId, 3'd1);

        // ack 2'b10 alone retires nothing
        applyStimulus(1'b1, 64'h4000, 2'b00, 1'b0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b0);
        setWb(3, 3'd1, 64'h4444, 1'b0, 64'd0);
        cycle();
        applyStimulus(1'b0, 64'd0, 2'b10, 1'b0);
        cycle();
        check("ack10_tid0", cInstr[0].trans_id, 3'd1);
        check("ack10_v0", cInstr[0].valid, 1'b1);
        applyStimulus(1'b0, 64'd0, 2'b01, 1'b0);
        cycle();

        // Full: ninth request blocked despite same-cycle retire
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'h5000 + 64'(i), 2'b00, 1'b0);
            if (i == 1) setWb(0, 3'd0, 64'h5555, 1'b0, 64'd0);
            cycle();
        end
        check("full_set", full, 1'b1);
        applyStimulus(1'b1, 64'h5100, 2'b01, 1'b0);
        #2;
        check("full_blocks_ack", ackO, 1'b0);
        cycle();
        check("full_clear", full, 1'b0);
        applyStimulus(1'b1, 64'h5200, 2'b00, 1'b0);
        #2;
        check("after_full_ack", ackO, 1'b1);
        check("after_full_id", issId, 3'd0);
        cycle();

        // Flush with four entries plus simultaneous allocate and writeback
        applyStimulus(1'b0, 64'd0, 2'b00, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 64'h6000 + 64'(i), 2'b00, 1'b0);
            cycle();
        end
        applyStimulus(1'b1, 64'h6100, 2'b00, 1'b1);
        setWb(0, 3'd1, 64'h6666, 1'b0, 64'd0);
        #2;
        check("flush_blocks_ack", ackO, 1'b0);
        cycle();
        check("flush_v0", cInstr[0].valid, 1'b0);
        check("flush_v1", cInstr[1].valid, 1'b0);
        check("flush_full", full, 1'b0);
        applyStimulus(1'b1, 64'h6200, 2'b00, 1'b0);
        #2;
        check("flush_next_id", issId, 3'd0);
        cycle();

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'h7000 + 64'(i), 2'b00, 1'b0);
            setWb(0, 3'd0, 64'h7777, 1'b0, 64'd0);
            cycle();
        end
        pulseReset();
        applyStimulus(1'b1, 64'h7100, 2'b00, 1'b0);
        #2;
        check("rst_next_ack", ackO, 1'b1);
        check("rst_next_id", issId, 3'd0);
        cycle();

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom},
                          2'($urandom_range(0, 3)), $urandom_range(0, 63) == 0);
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(0, 1) == 1)
                    setWb(p, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                          $urandom_range(0, 7) == 0, 64'($urandom));
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
